// File: rtl/md_pkg.sv
// md_pkg: shared op codes, FSM states and default latencies for the md sequencer
package md_pkg;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_e;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide result for latched op and operands
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);
  logic [63:0] prod;
  logic [31:0] ma, mb, dv, q, r;
  logic sd, sm;
  always_comb begin
    sd = op == MD_DIV;
    sm = op == MD_MULT;
    div_zero = (op == MD_DIV || op == MD_DIVU) && b == '0;
    ma = sd && a[31] ? -a : a;
    mb = sd && b[31] ? -b : b;
    // a zero divisor is replaced by 1; the result is discarded by the caller anyway
    dv = mb | {31'b0, b == '0};
    q = ma / dv;
    r = ma % dv;
    prod = {{32{sm & a[31]}}, a} * {{32{sm & b[31]}}, b};
    {hi, lo} = (op == MD_MULT || op == MD_MULTU) ? prod
             : {sd && a[31] ? -r : r, sd && (a[31] ^ b[31]) ? -q : q};
  end
endmodule

// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer with fixed-latency busy window and D-stage stall
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_in1,
  input  logic [31:0] md_in2,
  input  logic        d_md,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  md_state_e state;
  logic [CNT_W-1:0] cnt;
  logic [2:0] op_q;
  logic [31:0] a_q, b_q, hi_next, lo_next;
  logic div_zero, is_div;
  assign is_div = md_op == MD_DIV || md_op == MD_DIVU;
  assign start = reset && state == IDLE && (is_div || md_op == MD_MULT || md_op == MD_MULTU);
  assign stall = d_md & (start | busy);
  md_arith u_arith (
    .op(op_q),
    .a(a_q),
    .b(b_q),
    .hi(hi_next),
    .lo(lo_next),
    .div_zero(div_zero)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        op_q <= md_op;
        a_q <= md_in1;
        b_q <= md_in2;
        cnt <= is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
        busy <= 1'b1;
        state <= RUN;
      end else if (md_op == MD_MTHI) begin
        hi_out <= md_in1;
      end else if (md_op == MD_MTLO) begin
        lo_out <= md_in1;
      end
    end else if (cnt == '0) begin
      if (!div_zero) begin
        hi_out <= hi_next;
        lo_out <= lo_next;
      end
      busy <= 1'b0;
      state <= IDLE;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: randomized self-checking bench for md_sched against a behavioural model
module tb_md_sched;
  import md_pkg::*;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT = 10;
  logic clk = 0, reset = 0, d_md = 0;
  logic [2:0] md_op = MD_NONE;
  logic [31:0] md_in1 = 0, md_in2 = 0;
  logic start, busy, stall;
  logic [31:0] hi_out, lo_out;
  logic [31:0] m_hi = 0, m_lo = 0;
  int vectors = 0, miscompares = 0;

  md_sched dut (
    .clk(clk), .reset(reset), .md_op(md_op), .md_in1(md_in1), .md_in2(md_in2),
    .d_md(d_md), .start(start), .busy(busy), .stall(stall), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (busy) assert (md_op == MD_NONE) else $error("md_op issued while busy");

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint x, y;
    logic [63:0] p;
    sa = a;
    sb = b;
    x = sa;
    y = sb;
    case (op)
      MD_MULT: begin p = x * y; {m_hi, m_lo} = p; end
      MD_MULTU: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
      MD_DIV: if (b != 0) begin m_lo = 32'(x / y); m_hi = 32'(x % y); end
      MD_DIVU: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
  endtask

  // entered and left at negedge+1; the new op is accepted at the next posedge
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic dm);
    int lat;
    lat = (op == MD_DIV || op == MD_DIVU) ? DIV_LAT : MULT_LAT;
    md_op = op; md_in1 = a; md_in2 = b; d_md = dm;
    #1 check("start", 32'(start), 1);
    check("stall_start", 32'(stall), 32'(dm));
    model(op, a, b);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      md_op = MD_NONE; md_in1 = $urandom; md_in2 = $urandom;
      #1 check("busy", 32'(busy), 1);
      check("stall_busy", 32'(stall), 32'(dm));
      check("start_busy", 32'(start), 0);
    end
    @(negedge clk);
    #1 check("busy_fall", 32'(busy), 0);
    check("stall_fall", 32'(stall), 0);
    check("hi", hi_out, m_hi);
    check("lo", lo_out, m_lo);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    md_op = op; md_in1 = v;
    #1 check("start_mt", 32'(start), 0);
    if (op == MD_MTHI) m_hi = v; else m_lo = v;
    @(negedge clk);
    md_op = MD_NONE;
    #1 check("busy_mt", 32'(busy), 0);
    check("hi_mt", hi_out, m_hi);
    check("lo_mt", lo_out, m_lo);
  endtask

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    md_op = MD_MULT;
    d_md = 1;
    repeat (2) @(negedge clk);
    #1 check("rst_start", 32'(start), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    md_op = MD_NONE;
    d_md = 0;
    @(negedge clk);
    reset = 1;
    #1;
    run_op(MD_MULT, 32'hFFFFFFFE, 32'h3, 1);
    check("mult_hi", hi_out, 32'hFFFFFFFF);
    check("mult_lo", lo_out, 32'hFFFFFFFA);
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("multu_hi", hi_out, 32'hFFFFFFFE);
    check("multu_lo", lo_out, 32'h00000001);
    run_op(MD_DIV, 32'hFFFFFFF9, 32'h2, 1);
    check("div_lo", lo_out, 32'hFFFFFFFD);
    check("div_hi", hi_out, 32'hFFFFFFFF);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
    check("divov_lo", lo_out, 32'h80000000);
    check("divov_hi", hi_out, 32'h0);
    mt(MD_MTHI, 32'h11);
    mt(MD_MTLO, 32'h22);
    run_op(MD_DIVU, 32'd100, 32'd0, 1);
    check("dz_hi", hi_out, 32'h11);
    check("dz_lo", lo_out, 32'h22);
    // random ops, issued back-to-back in the cycle busy falls
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
      if (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) run_op(op, a, b, 1'($urandom));
      else if (op == MD_MTHI || op == MD_MTLO) mt(op, a);
      else begin
        md_op = op; d_md = 1'($urandom);
        #1 check("start_none", 32'(start), 0);
        check("stall_none", 32'(stall), 0);
        @(negedge clk);
        md_op = MD_NONE;
        #1 check("hold_hi", hi_out, m_hi);
        check("hold_lo", lo_out, m_lo);
      end
    end
    // abort mid-run when the counter reads 3
    md_op = MD_DIV; md_in1 = 32'd1000; md_in2 = 32'd7; d_md = 1;
    for (int i = 0; i < DIV_LAT - 3; i++) begin
      @(negedge clk);
      md_op = MD_NONE;
    end
    #1 check("pre_abort_busy", 32'(busy), 1);
    reset = 0;
    md_op = MD_MULT;
    #1 check("abort_busy", 32'(busy), 0);
    check("abort_hi", hi_out, 0);
    check("abort_lo", lo_out, 0);
    check("abort_start", 32'(start), 0);
    check("abort_stall", 32'(stall), 0);
    m_hi = 0;
    m_lo = 0;
    md_op = MD_NONE;
    @(negedge clk);
    reset = 1;
    #1 check("abort_hold_hi", hi_out, 0);
    @(negedge clk);
    #1;
    run_op(MD_MULT, 32'd2, 32'd3, 0);
    check("post_lo", lo_out, 32'd6);
    check("post_hi", hi_out, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencer for the E-stage multiply/divide resource.
- Decodes the E-stage md operation and latches its operands.
- Runs a fixed-latency busy window, then commits HI/LO.
- Raises the D-stage stall request that the hazard unit ORs into its stall enable, so a dependent md instruction cannot issue while the unit is occupied.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (min 1)
- DIV_LAT, 10, busy cycles for div/divu (min 1)
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- md_op  in  3  E-stage operation code (see package)
- md_in1  in  32  rs operand (forwarded Src1)
- md_in2  in  32  rt operand (forwarded Src2)
- d_md  in  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- start  out  1  combinational; 1 in the cycle a mult/div op is accepted
- busy  out  1  registered; 1 while an operation is in flight
- stall  out  1  combinational; d_md & (start | busy)
- hi_out  out  32  HI register
- lo_out  out  32  LO register

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, busy=0, hi_out=0, lo_out=0, operand/op latches=0. start and stall evaluate to 0 while reset is low.
- States: IDLE, RUN.
- IDLE, md_op in {MULT, MULTU, DIV, DIVU}:
  - start=1.
  - At the clock edge: latch md_in1, md_in2 and md_op; cnt <= LAT-1 (LAT per op); busy <= 1; go to RUN.
- IDLE, MTHI/MTLO: hi_out (resp. lo_out) <= md_in1 at the clock edge; no busy.
- IDLE, MD_NONE: hold.
- RUN:
  - cnt decrements each cycle.
  - When cnt==0: commit HI/LO from the latched operands; busy <= 0; return to IDLE.
- Timing: start in cycle T → busy high in cycles T+1 .. T+LAT; HI/LO readable from cycle T+LAT+1, the same cycle busy falls.
- Any md_op in RUN is ignored. The stall contract guarantees this never occurs; the bench asserts it.
- MFHI/MFLO do not enter this block. The datapath muxes hi_out/lo_out; the stall prevents reads during RUN.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 → 64-bit product.
  - MULTU: same, unsigned.
  - DIV: lo = quotient truncated toward zero; hi = remainder, taking the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (either signedness): full DIV_LAT busy window, then hi/lo unchanged.
- Operands are latched at start; later changes on md_in1/md_in2 have no effect on the result.
- Back-to-back issue: a new op is accepted in the cycle busy falls (state IDLE), earliest T+LAT+1.
- Reset asserted during RUN: immediate abort, hi/lo cleared, no commit.

Decomposition:
- Shared package md_pkg:
  - md_op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6 (7 reserved, treated as NONE).
  - State encoding: IDLE=0, RUN=1.
  - Default latencies.
- One natural sub-module, md_arith: combinational; takes latched op/operands and returns {hi_next, lo_next, div_zero}.
- md_sched keeps the FSM, counter and HI/LO registers.

Test Plan:
- MULT 0xFFFFFFFE × 0x00000003 at T: start=1 at T; busy T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV:
  - -7 / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU 100/0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO: busy 10 cycles, then hi=0x11, lo=0x22.
- Stall: d_md=1 during start and every busy cycle → stall=1; stall=0 on the first cycle busy=0; d_md=0 → stall=0 throughout.
- Reset: drop reset low mid-RUN at cnt=3 → busy=0, hi=lo=0 immediately; after release a new MULT 2×3 gives lo=6, hi=0.
